pr_pattern_gen_mc: RTL and testbench

Parametrised, multi-channel successor to the single 16-bit partial-reconfiguration test source. It is a reconfigurable-partition data generator. It produces NUM_CH independent DATA_W-bit pattern streams in one of four run-time-selectable modes and drives the static region's capture logic. It adds start/stop control, a valid strobe, a wrap indicator and a decouple handshake so the static side can quiesce it before a partial bitstream load.

---
 rtl/pr_pattern_gen_mc_if.sv | 40 ++++
 rtl/pr_pattern_gen_mc.sv | 150 +++++++++++++++
 tb/tb_pr_pattern_gen_mc.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr_pattern_gen_mc_if.sv
// Control/data bundle between the static region and the pattern-generator partition.
// master = static-side controller, slave = generator.
interface pr_pattern_gen_mc_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4
);
  logic [1:0]               mode;
  logic                     start;
  logic                     stop;
  logic                     decouple_req;
  logic                     decouple_ack;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic                     data_valid;
  logic                     busy;
  logic                     wrap_pulse;

  modport master (
    output mode,
    output start,
    output stop,
    output decouple_req,
    input  decouple_ack,
    input  data_out,
    input  data_valid,
    input  busy,
    input  wrap_pulse
  );

  modport slave (
    input  mode,
    input  start,
    input  stop,
    input  decouple_req,
    output decouple_ack,
    output data_out,
    output data_valid,
    output busy,
    output wrap_pulse
  );
endinterface

// File: rtl/pr_pattern_gen_mc.sv
// Multi-channel reconfigurable-partition pattern source: up/down count, Galois LFSR
// or walking-one per channel, with start/stop control and a decouple handshake.
//
// state       | meaning
// S_IDLE      | stopped, data_out holds last sample, waiting for start
// S_RUN       | one new sample per channel every cycle
// S_DECOUPLED | quiesced for partial reload, outputs forced to 0, ack high
module pr_pattern_gen_mc #(
  parameter int                DATA_W    = 16,
  parameter int                NUM_CH    = 4,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(16'hB400)
) (
  input  logic               clk,
  input  logic               rst_n,
  pr_pattern_gen_mc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_DECOUPLED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_data [NUM_CH];
  logic              r_valid;
  logic              r_busy;
  logic              r_wrap;
  logic              r_ack;

  logic [DATA_W-1:0]        w_seed [NUM_CH];
  logic [DATA_W-1:0]        w_next [NUM_CH];
  logic                     w_wrap;
  logic [NUM_CH*DATA_W-1:0] w_data_out;

  // Seeds depend on the live mode input since they load on the same edge the mode is latched.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_seed[c] = '0;
      case (bus.mode)
        MODE_UP, MODE_DOWN: w_seed[c] = DATA_W'(c);
        MODE_LFSR:          w_seed[c] = DATA_W'(c + 1);
        default:            w_seed[c] = DATA_W'(1) << (c % DATA_W);
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_next[c] = r_data[c];
      case (r_mode)
        MODE_UP:   w_next[c] = r_data[c] + DATA_W'(1);
        MODE_DOWN: w_next[c] = r_data[c] - DATA_W'(1);
        MODE_LFSR: w_next[c] = r_data[c][0] ? ((r_data[c] >> 1) ^ LFSR_POLY)
                                            : (r_data[c] >> 1);
        default:   w_next[c] = {r_data[c][DATA_W-2:0], r_data[c][DATA_W-1]};
      endcase
    end
  end

  always_comb begin
    w_wrap = 1'b0;
    if (r_mode == MODE_UP)
      w_wrap = (r_data[0] == {DATA_W{1'b1}});
    else if (r_mode == MODE_DOWN)
      w_wrap = (r_data[0] == '0);
  end

  always_comb begin
    w_data_out = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_data_out[c*DATA_W +: DATA_W] = r_data[c];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_UP;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_ack   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        r_data[c] <= '0;
    end else if (bus.decouple_req) begin
      r_state <= S_DECOUPLED;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_ack   <= 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        r_data[c] <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_mode  <= bus.mode;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            for (int c = 0; c < NUM_CH; c++)
              r_data[c] <= w_seed[c];
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_wrap  <= w_wrap;
            for (int c = 0; c < NUM_CH; c++)
              r_data[c] <= w_next[c];
          end
        end
        S_DECOUPLED: begin
          // Leaving quiesce always lands in IDLE; the next run reloads seeds.
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out     = w_data_out;
  assign bus.data_valid   = r_valid;
  assign bus.busy         = r_busy;
  assign bus.wrap_pulse   = r_wrap;
  assign bus.decouple_ack = r_ack;

endmodule

// File: tb/tb_pr_pattern_gen_mc.sv
// Directed bench for pr_pattern_gen_mc: default 16-bit x4 instance plus a 4-bit x2
// instance so the up-count wrap is reachable in a few cycles.
module tb_pr_pattern_gen_mc;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pr_pattern_gen_mc_if #(.DATA_W(16), .NUM_CH(4)) bus ();
  pr_pattern_gen_mc_if #(.DATA_W(4),  .NUM_CH(2)) b4 ();

  pr_pattern_gen_mc #(.DATA_W(16), .NUM_CH(4), .LFSR_POLY(16'hB400)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pr_pattern_gen_mc #(.DATA_W(4), .NUM_CH(2), .LFSR_POLY(4'hC)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ch(input int c);
    return bus.data_out[c*16 +: 16];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.busy, bus.wrap_pulse, bus.decouple_ack} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got data=%h v=%b b=%b w=%b a=%b exp all 0",
               bus.data_out, bus.data_valid, bus.busy, bus.wrap_pulse, bus.decouple_ack);
    end
    n_tests++;
    if ({b4.data_out, b4.data_valid, b4.busy, b4.wrap_pulse, b4.decouple_ack} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_narrow got data=%h v=%b b=%b exp all 0", b4.data_out, b4.data_valid, b4.busy);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_up_count();
    bus.mode = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ch(0) !== 16'(k) || ch(3) !== 16'(k + 3) || bus.data_valid !== 1'b1 ||
          bus.busy !== 1'b1 || bus.wrap_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL up_seq k=%0d got ch0=%h ch3=%h v=%b b=%b w=%b exp ch0=%h ch3=%h v=1 b=1 w=0",
                 k, ch(0), ch(3), bus.data_valid, bus.busy, bus.wrap_pulse, 16'(k), 16'(k + 3));
      end
      bus.mode = 2'(k + 1);  // mode changes during RUN must be ignored
      tick();
    end
    bus.stop = 1'b1;
    tick();
    n_tests++;
    if (ch(0) !== 16'h0004 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL up_stop got ch0=%h v=%b b=%b exp ch0=0004 v=0 b=0", ch(0), bus.data_valid, bus.busy);
    end
    tick();
    n_tests++;
    if (ch(0) !== 16'h0004 || ch(3) !== 16'h0007 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_stop got ch0=%h ch3=%h v=%b exp ch0=0004 ch3=0007 v=0",
               ch(0), ch(3), bus.data_valid);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_down_count();
    logic [15:0] e0 [3] = '{16'h0000, 16'hFFFF, 16'hFFFE};
    logic [15:0] e1 [3] = '{16'h0001, 16'h0000, 16'hFFFF};
    logic        ew [3] = '{1'b0, 1'b1, 1'b0};
    bus.mode = 2'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ch(0) !== e0[k] || ch(1) !== e1[k] || bus.wrap_pulse !== ew[k] || bus.data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL down_seq k=%0d got ch0=%h ch1=%h w=%b v=%b exp ch0=%h ch1=%h w=%b v=1",
                 k, ch(0), ch(1), bus.wrap_pulse, bus.data_valid, e0[k], e1[k], ew[k]);
      end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_lfsr();
    logic [15:0] e0 [4] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
    logic [15:0] e1 [4] = '{16'h0002, 16'h0001, 16'hB400, 16'h5A00};
    bus.mode = 2'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (ch(3) !== 16'h0004) begin
      n_fail++;
      $display("FAIL lfsr_seed3 got %h exp 0004", ch(3));
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ch(0) !== e0[k] || ch(1) !== e1[k] || bus.wrap_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL lfsr_seq k=%0d got ch0=%h ch1=%h w=%b exp ch0=%h ch1=%h w=0",
                 k, ch(0), ch(1), bus.wrap_pulse, e0[k], e1[k]);
      end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_walk();
    logic [15:0] e;
    bus.mode = 2'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (ch(2) !== 16'h0004) begin
      n_fail++;
      $display("FAIL walk_seed2 got %h exp 0004", ch(2));
    end
    for (int k = 0; k < 17; k++) begin
      e = 16'h0001 << (k % 16);
      n_tests++;
      if (ch(0) !== e || bus.wrap_pulse !== 1'b0 || bus.data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL walk_seq k=%0d got ch0=%h w=%b v=%b exp ch0=%h w=0 v=1",
                 k, ch(0), bus.wrap_pulse, bus.data_valid, e);
      end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_decouple();
    bus.mode = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (ch(0) !== 16'h0005) begin
      n_fail++;
      $display("FAIL dec_pre got ch0=%h exp 0005", ch(0));
    end
    bus.decouple_req = 1'b1;
    bus.start = 1'b1;  // must be ignored while quiesced
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (bus.decouple_ack !== 1'b1 || bus.data_out !== 64'h0 || bus.data_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL dec_hold k=%0d got a=%b data=%h v=%b b=%b exp a=1 data=0 v=0 b=0",
                 k, bus.decouple_ack, bus.data_out, bus.data_valid, bus.busy);
      end
    end
    bus.decouple_req = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.decouple_ack !== 1'b0 || bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL dec_release got a=%b v=%b b=%b data=%h exp a=0 v=0 b=0 data=0",
               bus.decouple_ack, bus.data_valid, bus.busy, bus.data_out);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (ch(0) !== 16'h0000 || ch(3) !== 16'h0003 || bus.data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_restart got ch0=%h ch3=%h v=%b exp ch0=0000 ch3=0003 v=1",
               ch(0), ch(3), bus.data_valid);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_start_stop();
    bus.mode = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    n_tests++;
    if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || ch(0) !== 16'h0001 || ch(3) !== 16'h0004) begin
      n_fail++;
      $display("FAIL both_run got v=%b b=%b ch0=%h ch3=%h exp v=0 b=0 ch0=0001 ch3=0004",
               bus.data_valid, bus.busy, ch(0), ch(3));
    end
    tick();  // start+stop together in IDLE: start accepted
    bus.start = 1'b0;
    bus.stop = 1'b0;
    n_tests++;
    if (bus.data_valid !== 1'b1 || bus.busy !== 1'b1 || ch(0) !== 16'h0000) begin
      n_fail++;
      $display("FAIL both_idle got v=%b b=%b ch0=%h exp v=1 b=1 ch0=0000", bus.data_valid, bus.busy, ch(0));
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if ({bus.data_out, bus.data_valid, bus.busy, bus.wrap_pulse, bus.decouple_ack} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_midrun got data=%h v=%b b=%b exp all 0", bus.data_out, bus.data_valid, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_idle got v=%b data=%h exp v=0 data=0", bus.data_valid, bus.data_out);
    end
  endtask

  task automatic test_up_wrap();
    b4.mode = 2'd0;
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      n_tests++;
      if (b4.data_out[3:0] !== 4'(k) || b4.data_out[7:4] !== 4'(k + 1) ||
          b4.wrap_pulse !== (k == 16)) begin
        n_fail++;
        $display("FAIL up_wrap k=%0d got ch0=%h ch1=%h w=%b exp ch0=%h ch1=%h w=%b",
                 k, b4.data_out[3:0], b4.data_out[7:4], b4.wrap_pulse, 4'(k), 4'(k + 1), (k == 16));
      end
      tick();
    end
    b4.stop = 1'b1;
    tick();
    b4.stop = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.mode = 2'd0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.decouple_req = 1'b0;
    b4.mode = 2'd0;
    b4.start = 1'b0;
    b4.stop = 1'b0;
    b4.decouple_req = 1'b0;
    test_reset();
    test_up_count();
    test_down_count();
    test_lfsr();
    test_walk();
    test_decouple();
    test_start_stop();
    test_up_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
